// File: rtl/instruction_decode_hazard_stage.sv
// ID stage: decode, register file with write-through bypass, load-use and branch-operand
// hazard detection, beq/bne/j resolution, and a registered ID/EX pipeline register.
module instruction_decode_hazard_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           instructionInput,
    input  logic [DATA_WIDTH-1:0] pc4Input,
    input  logic                  validInput,
    input  logic                  regWriteInput,
    input  logic [4:0]            writeRegisterInput,
    input  logic [DATA_WIDTH-1:0] writeDataInput,
    input  logic                  exMemRegWriteInput,
    input  logic                  exMemMemReadInput,
    input  logic [4:0]            exMemWriteRegisterInput,
    output logic                  stallOutput,
    output logic                  ifFlushOutput,
    output logic                  pcRedirectOutput,
    output logic [DATA_WIDTH-1:0] pcTargetOutput,
    output logic                  validOutput,
    output logic                  memToRegOutput,
    output logic                  regWriteOutput,
    output logic                  memWriteOutput,
    output logic                  memReadOutput,
    output logic                  aluSrcOutput,
    output logic [3:0]            aluOpOutput,
    output logic [DATA_WIDTH-1:0] dataRsOutput,
    output logic [DATA_WIDTH-1:0] dataRtOutput,
    output logic [DATA_WIDTH-1:0] immediateExtendedOutput,
    output logic [4:0]            addressRsOutput,
    output logic [4:0]            addressRtOutput,
    output logic [4:0]            writeRegisterOutput,
    output logic [5:0]            funcOutput
);

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_J    = 6'h02;

    function automatic logic signed [DATA_WIDTH-1:0] sext16(input logic signed [15:0] v);
        return DATA_WIDTH'(v);
    endfunction

    function automatic logic in_range(input logic [4:0] idx);
        return int'(idx) < NUM_REGS;
    endfunction

    logic [DATA_WIDTH-1:0] regs [32];

    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm16;

    assign opcode = instructionInput[31:26];
    assign rs     = instructionInput[25:21];
    assign rt     = instructionInput[20:16];
    assign rd     = instructionInput[15:11];
    assign imm16  = instructionInput[15:0];

    logic [DATA_WIDTH-1:0] rs_data, rt_data;

    always_comb begin
        rs_data = '0;
        rt_data = '0;
        if (rs != 5'd0 && in_range(rs)) begin
            if (regWriteInput && writeRegisterInput == rs) rs_data = writeDataInput;
            else                                           rs_data = regs[rs];
        end
        if (rt != 5'd0 && in_range(rt)) begin
            if (regWriteInput && writeRegisterInput == rt) rt_data = writeDataInput;
            else                                           rt_data = regs[rt];
        end
    end

    logic                  reg_dst, reg_write, alu_src, mem_read, mem_write, mem_to_reg;
    logic [3:0]            alu_op;
    logic [DATA_WIDTH-1:0] imm_ext;
    logic                  uses_rs, uses_rt, is_beq, is_bne, is_j;

    always_comb begin
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        alu_src    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_op     = 4'b0000;
        imm_ext    = sext16(imm16);
        uses_rs    = 1'b1;
        uses_rt    = 1'b0;
        is_beq     = 1'b0;
        is_bne     = 1'b0;
        is_j       = 1'b0;
        case (opcode)
            OP_R: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                alu_op    = 4'b0010;
                uses_rt   = 1'b1;
            end
            OP_LW: begin
                alu_src    = 1'b1;
                mem_read   = 1'b1;
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            OP_SW: begin
                alu_src   = 1'b1;
                mem_write = 1'b1;
                uses_rt   = 1'b1;
            end
            OP_ADDI: begin
                alu_src   = 1'b1;
                reg_write = 1'b1;
            end
            OP_ORI: begin
                alu_src   = 1'b1;
                reg_write = 1'b1;
                alu_op    = 4'b0011;
                imm_ext   = {{(DATA_WIDTH-16){1'b0}}, imm16};
            end
            OP_BEQ: begin
                alu_op  = 4'b0001;
                uses_rt = 1'b1;
                is_beq  = 1'b1;
            end
            OP_BNE: begin
                alu_op  = 4'b0001;
                uses_rt = 1'b1;
                is_bne  = 1'b1;
            end
            OP_J: begin
                uses_rs = 1'b0;
                is_j    = 1'b1;
            end
            default: ;
        endcase
    end

    logic [4:0] write_reg;
    assign write_reg = reg_dst ? rd : rt;

    // ID/EX pipeline register state
    logic                  vld_p1, mem_to_reg_p1, reg_write_p1, mem_write_p1, mem_read_p1, alu_src_p1;
    logic [3:0]            alu_op_p1;
    logic [DATA_WIDTH-1:0] rs_data_p1, rt_data_p1, imm_p1;
    logic [4:0]            rs_p1, rt_p1, wr_p1;
    logic [5:0]            func_p1;

    // A load sitting in MEM is itself a register writer, so it folds into the writer term.
    logic ex_mem_writer;
    assign ex_mem_writer = exMemRegWriteInput | (exMemRegWriteInput & exMemMemReadInput);

    logic load_use, branch_haz, stall_raw, operands_equal, taken;
    logic [DATA_WIDTH-1:0] target;

    always_comb begin
        load_use = vld_p1 && mem_read_p1 && wr_p1 != 5'd0 &&
                   ((uses_rs && wr_p1 == rs) || (uses_rt && wr_p1 == rt));
        branch_haz = (is_beq || is_bne) &&
                     ((vld_p1 && reg_write_p1 && wr_p1 != 5'd0 && (wr_p1 == rs || wr_p1 == rt)) ||
                      (ex_mem_writer && exMemWriteRegisterInput != 5'd0 &&
                       (exMemWriteRegisterInput == rs || exMemWriteRegisterInput == rt)));
        stall_raw      = validInput && (load_use || branch_haz);
        operands_equal = (rs_data == rt_data);
        taken = validInput && !stall_raw &&
                (is_j || (is_beq && operands_equal) || (is_bne && !operands_equal));
        if (is_j) target = {pc4Input[DATA_WIDTH-1:28], instructionInput[25:0], 2'b00};
        else      target = pc4Input + DATA_WIDTH'(sext16(imm16) <<< 2);
    end

    assign stallOutput      = reset && stall_raw;
    assign pcRedirectOutput = reset && taken;
    assign ifFlushOutput    = reset && taken;
    assign pcTargetOutput   = (reset && taken) ? target : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (regWriteInput && writeRegisterInput != 5'd0 && in_range(writeRegisterInput)) begin
            regs[writeRegisterInput] <= writeDataInput;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset || !(validInput && !stall_raw)) begin
            vld_p1        <= 1'b0;
            mem_to_reg_p1 <= 1'b0;
            reg_write_p1  <= 1'b0;
            mem_write_p1  <= 1'b0;
            mem_read_p1   <= 1'b0;
            alu_src_p1    <= 1'b0;
            alu_op_p1     <= 4'b0000;
            rs_data_p1    <= '0;
            rt_data_p1    <= '0;
            imm_p1        <= '0;
            rs_p1         <= 5'd0;
            rt_p1         <= 5'd0;
            wr_p1         <= 5'd0;
            func_p1       <= 6'd0;
        end else begin
            vld_p1        <= 1'b1;
            mem_to_reg_p1 <= mem_to_reg;
            reg_write_p1  <= reg_write;
            mem_write_p1  <= mem_write;
            mem_read_p1   <= mem_read;
            alu_src_p1    <= alu_src;
            alu_op_p1     <= alu_op;
            rs_data_p1    <= rs_data;
            rt_data_p1    <= rt_data;
            imm_p1        <= imm_ext;
            rs_p1         <= rs;
            rt_p1         <= rt;
            wr_p1         <= write_reg;
            func_p1       <= instructionInput[5:0];
        end
    end

    assign validOutput             = vld_p1;
    assign memToRegOutput          = mem_to_reg_p1;
    assign regWriteOutput          = reg_write_p1;
    assign memWriteOutput          = mem_write_p1;
    assign memReadOutput           = mem_read_p1;
    assign aluSrcOutput            = alu_src_p1;
    assign aluOpOutput             = alu_op_p1;
    assign dataRsOutput            = rs_data_p1;
    assign dataRtOutput            = rt_data_p1;
    assign immediateExtendedOutput = imm_p1;
    assign addressRsOutput         = rs_p1;
    assign addressRtOutput         = rt_p1;
    assign writeRegisterOutput     = wr_p1;
    assign funcOutput              = func_p1;

endmodule

// File: tb/tb_instruction_decode_hazard_stage.sv
// Scoreboard bench for instruction_decode_hazard_stage: directed scenarios followed by
// randomized traffic checked against a behavioural model of the decode/hazard rules.
module tb_instruction_decode_hazard_stage;

    localparam int DW = 32;
    localparam int NR = 16;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OPS [9] = '{OP_R, OP_LW, OP_SW, OP_ADDI, OP_ORI, OP_BEQ, OP_BNE, OP_J, 6'h3F};

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [31:0] instructionInput = '0;
    logic [DW-1:0] pc4Input = '0;
    logic validInput = 1'b0;
    logic regWriteInput = 1'b0;
    logic [4:0] writeRegisterInput = '0;
    logic [DW-1:0] writeDataInput = '0;
    logic exMemRegWriteInput = 1'b0;
    logic exMemMemReadInput = 1'b0;
    logic [4:0] exMemWriteRegisterInput = '0;
    logic stallOutput, ifFlushOutput, pcRedirectOutput;
    logic [DW-1:0] pcTargetOutput;
    logic validOutput, memToRegOutput, regWriteOutput, memWriteOutput, memReadOutput, aluSrcOutput;
    logic [3:0] aluOpOutput;
    logic [DW-1:0] dataRsOutput, dataRtOutput, immediateExtendedOutput;
    logic [4:0] addressRsOutput, addressRtOutput, writeRegisterOutput;
    logic [5:0] funcOutput;

    instruction_decode_hazard_stage #(.DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
        .clk(clk), .reset(reset),
        .instructionInput(instructionInput), .pc4Input(pc4Input), .validInput(validInput),
        .regWriteInput(regWriteInput), .writeRegisterInput(writeRegisterInput),
        .writeDataInput(writeDataInput), .exMemRegWriteInput(exMemRegWriteInput),
        .exMemMemReadInput(exMemMemReadInput), .exMemWriteRegisterInput(exMemWriteRegisterInput),
        .stallOutput(stallOutput), .ifFlushOutput(ifFlushOutput),
        .pcRedirectOutput(pcRedirectOutput), .pcTargetOutput(pcTargetOutput),
        .validOutput(validOutput), .memToRegOutput(memToRegOutput),
        .regWriteOutput(regWriteOutput), .memWriteOutput(memWriteOutput),
        .memReadOutput(memReadOutput), .aluSrcOutput(aluSrcOutput), .aluOpOutput(aluOpOutput),
        .dataRsOutput(dataRsOutput), .dataRtOutput(dataRtOutput),
        .immediateExtendedOutput(immediateExtendedOutput), .addressRsOutput(addressRsOutput),
        .addressRtOutput(addressRtOutput), .writeRegisterOutput(writeRegisterOutput),
        .funcOutput(funcOutput)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        mem_to_reg, reg_write, mem_write, mem_read, alu_src;
        logic [3:0]  alu_op;
        logic [31:0] rs_data, rt_data, imm;
        logic [4:0]  rs, rt, wr;
        logic [5:0]  func;
    } idex_t;

    idex_t exp_q[$];
    idex_t mon_e;
    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    logic [31:0] m_regs [32];
    bit m_vld, m_memread, m_regwrite;
    logic [4:0] m_wr;
    logic s_stall, s_redir, s_flush;
    logic [31:0] s_target;
    int stall_cnt;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic idex_t actual_idex();
        return '{memToRegOutput, regWriteOutput, memWriteOutput, memReadOutput, aluSrcOutput,
                 aluOpOutput, dataRsOutput, dataRtOutput, immediateExtendedOutput,
                 addressRsOutput, addressRtOutput, writeRegisterOutput, funcOutput};
    endfunction

    task automatic check_all_zero(input string name);
        check({name, "_comb"}, 128'({stallOutput, ifFlushOutput, pcRedirectOutput, pcTargetOutput}), 128'(0));
        check({name, "_idex"}, 128'({validOutput, actual_idex()}), 128'(0));
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_vld = 0; m_memread = 0; m_regwrite = 0; m_wr = '0;
        exp_q.delete();
    endtask

    always @(negedge clk) begin
        if (mon_en && reset) begin
            if (validOutput) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL idex_unexpected: got valid entry %h, required none", actual_idex());
                end else begin
                    mon_e = exp_q.pop_front();
                    check("idex_entry", 128'(actual_idex()), 128'(mon_e));
                end
            end else begin
                check("bubble_ctrl", 128'({memToRegOutput, regWriteOutput, memWriteOutput,
                      memReadOutput, aluSrcOutput, aluOpOutput}), 128'(0));
            end
        end
    end

    function automatic logic [31:0] m_read(input logic [4:0] idx, input bit we,
                                            input logic [4:0] widx, input logic [31:0] wd);
        if (idx == 0 || idx >= NR) return 32'd0;
        if (we && widx == idx) return wd;
        return m_regs[idx];
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        return {OP_R, rs, rt, rd, 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // One ID cycle: starts 1 time unit after a rising edge, ends 1 unit after the next one.
    task automatic cycle(input logic [31:0] ins, input logic [31:0] pc4, input bit vi,
                         input bit we, input logic [4:0] widx, input logic [31:0] wd,
                         input bit emw, input bit emr, input logic [4:0] emi);
        logic [5:0] op;
        logic [4:0] rs, rt;
        logic [31:0] a, b, tgt, sx;
        bit use_rs, use_rt, br, hz, stall, take;
        idex_t e;
        op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16];
        instructionInput = ins; pc4Input = pc4; validInput = vi;
        regWriteInput = we; writeRegisterInput = widx; writeDataInput = wd;
        exMemRegWriteInput = emw; exMemMemReadInput = emr; exMemWriteRegisterInput = emi;
        a = m_read(rs, we, widx, wd);
        b = m_read(rt, we, widx, wd);
        sx = {{16{ins[15]}}, ins[15:0]};
        e = '0;
        e.rs_data = a; e.rt_data = b; e.rs = rs; e.rt = rt; e.wr = rt;
        e.func = ins[5:0]; e.imm = sx;
        case (op)
            OP_R:    begin e.wr = ins[15:11]; e.reg_write = 1; e.alu_op = 4'b0010; end
            OP_LW:   begin e.alu_src = 1; e.mem_read = 1; e.mem_to_reg = 1; e.reg_write = 1; end
            OP_SW:   begin e.alu_src = 1; e.mem_write = 1; end
            OP_ADDI: begin e.alu_src = 1; e.reg_write = 1; end
            OP_ORI:  begin e.alu_src = 1; e.reg_write = 1; e.alu_op = 4'b0011; e.imm = {16'd0, ins[15:0]}; end
            OP_BEQ, OP_BNE: e.alu_op = 4'b0001;
            default: ;
        endcase
        use_rs = (op != OP_J);
        use_rt = (op == OP_R || op == OP_SW || op == OP_BEQ || op == OP_BNE);
        br = (op == OP_BEQ || op == OP_BNE);
        hz = m_vld && m_memread && m_wr != 0 && ((use_rs && m_wr == rs) || (use_rt && m_wr == rt));
        if (br && m_vld && m_regwrite && m_wr != 0 && (m_wr == rs || m_wr == rt)) hz = 1;
        if (br && emw && emi != 0 && (emi == rs || emi == rt)) hz = 1;
        stall = vi && hz;
        take = vi && !stall && (op == OP_J || (op == OP_BEQ && a == b) || (op == OP_BNE && a != b));
        tgt = (op == OP_J) ? {pc4[31:28], ins[25:0], 2'b00} : pc4 + (sx << 2);
        #3;
        s_stall = stallOutput; s_redir = pcRedirectOutput; s_flush = ifFlushOutput; s_target = pcTargetOutput;
        check("stall", 128'(stallOutput), 128'(stall));
        check("redirect", 128'(pcRedirectOutput), 128'(take));
        check("flush", 128'(ifFlushOutput), 128'(take));
        if (take) check("target", 128'(pcTargetOutput), 128'(tgt));
        if (vi && !stall) exp_q.push_back(e);
        @(posedge clk);
        if (we && widx != 0 && widx < NR) m_regs[widx] = wd;
        m_vld = vi && !stall;
        m_memread = m_vld && e.mem_read;
        m_regwrite = m_vld && e.reg_write;
        m_wr = m_vld ? e.wr : 5'd0;
        #1;
    endtask

    logic [31:0] r_ins;
    logic [4:0] r_widx, r_emi;

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset_low");
        reset = 1'b1;
        #1;
        check_all_zero("reset_release");
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        cycle(enc_i(OP_LW, 0, 8, 0), 32'h4, 1, 0, 0, 0, 0, 0, 0);
        check("lw_valid", 128'(validOutput), 128'(1));
        check("lw_memread", 128'(memReadOutput), 128'(1));
        check("lw_wr", 128'(writeRegisterOutput), 128'(8));
        check("lw_aluop", 128'(aluOpOutput), 128'(0));

        cycle(enc_r(9, 9, 10), 32'h8, 1, 1, 9, 32'h1234, 0, 0, 0);
        check("bypass_rs", 128'(dataRsOutput), 128'(32'h1234));
        check("bypass_rt", 128'(dataRtOutput), 128'(32'h1234));

        cycle(enc_i(OP_LW, 0, 8, 0), 32'hC, 1, 0, 0, 0, 0, 0, 0);
        cycle(enc_r(8, 8, 11), 32'h10, 1, 0, 0, 0, 0, 0, 0);
        check("lu_stall", 128'(s_stall), 128'(1));
        check("lu_bubble", 128'(validOutput), 128'(0));
        cycle(enc_r(8, 8, 11), 32'h10, 1, 0, 0, 0, 0, 0, 0);
        check("lu_release", 128'(s_stall), 128'(0));
        check("lu_issue_valid", 128'(validOutput), 128'(1));
        check("lu_issue_wr", 128'(writeRegisterOutput), 128'(11));

        cycle(enc_i(OP_BEQ, 8, 8, 16'd4), 32'h100, 1, 0, 0, 0, 0, 0, 0);
        check("beq_redirect", 128'(s_redir), 128'(1));
        check("beq_flush", 128'(s_flush), 128'(1));
        check("beq_target", 128'(s_target), 128'(32'h110));
        cycle(enc_i(OP_BNE, 8, 8, 16'd4), 32'h104, 1, 0, 0, 0, 0, 0, 0);
        check("bne_equal_no_redirect", 128'(s_redir), 128'(0));

        stall_cnt = 0;
        cycle(enc_i(OP_LW, 0, 8, 0), 32'h200, 1, 0, 0, 0, 0, 0, 0);
        cycle(enc_i(OP_BEQ, 8, 0, 16'd2), 32'h204, 1, 0, 0, 0, 0, 0, 0);
        stall_cnt += int'(s_stall);
        cycle(enc_i(OP_BEQ, 8, 0, 16'd2), 32'h204, 1, 0, 0, 0, 1, 1, 8);
        stall_cnt += int'(s_stall);
        cycle(enc_i(OP_BEQ, 8, 0, 16'd2), 32'h204, 1, 1, 8, 0, 0, 0, 0);
        check("lb_resolve", 128'(s_stall), 128'(0));
        check("lb_stall_cycles", 128'(stall_cnt), 128'(2));
        check("lb_target", 128'(s_target), 128'(32'h20C));

        cycle(32'h0, 32'h0, 0, 1, 20, 32'd5, 0, 0, 0);
        cycle(enc_r(20, 20, 12), 32'h300, 1, 0, 0, 0, 0, 0, 0);
        check("oob_read", 128'(dataRsOutput), 128'(0));
        cycle({OP_J, 26'h40}, 32'h10000004, 1, 0, 0, 0, 0, 0, 0);
        check("j_redirect", 128'(s_redir), 128'(1));
        check("j_target", 128'(s_target), 128'(32'h10000100));

        cycle(enc_i(OP_LW, 0, 8, 0), 32'h400, 1, 0, 0, 0, 0, 0, 0);
        instructionInput = enc_r(8, 8, 11); pc4Input = 32'h404; validInput = 1;
        regWriteInput = 0; exMemRegWriteInput = 0; exMemMemReadInput = 0;
        #3;
        check("mid_stall", 128'(stallOutput), 128'(1));
        #3;
        reset = 1'b0;
        #1;
        check_all_zero("reset_mid_stall");
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;

        for (int n = 0; n < 600; n++) begin
            r_ins = $urandom;
            r_ins[31:26] = OPS[$urandom_range(0, 8)];
            r_ins[25:21] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            r_ins[20:16] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            r_ins[15:11] = 5'($urandom_range(0, 7));
            r_widx = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            r_emi  = 5'($urandom_range(0, 7));
            cycle(r_ins, $urandom & 32'hFFFF_FFFC, $urandom_range(0, 9) != 0,
                  1'($urandom_range(0, 1)), r_widx, ($urandom_range(0, 2) == 0) ? 32'd0 : $urandom,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), r_emi);
        end

        cycle(32'h0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
        cycle(32'h0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
        check("queue_drained", 128'(exp_q.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_decode_hazard_stage.md
Name: instruction_decode_hazard_stage

Overview:
- Parametrised successor to the single-cycle-style decode stage.
- Decodes one instruction per cycle and holds its own register file with write-through bypass.
- Detects load-use and branch-operand hazards, stalls IF, and resolves beq/bne/j in ID.
- Drives a registered ID/EX pipeline register with a valid bit.

Parameters:
DATA_WIDTH, 32, datapath/PC width; legal range is 32 or more.
NUM_REGS, 32, implemented registers (2..32). Reads of index >= NUM_REGS return 0; writes to them are ignored.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low; reset=0 clears all state
instructionInput  in  32  IF/ID instruction
pc4Input  in  DATA_WIDTH  IF/ID PC+4
validInput  in  1  IF/ID entry valid
regWriteInput  in  1  WB write enable
writeRegisterInput  in  5  WB destination
writeDataInput  in  DATA_WIDTH  WB data
exMemRegWriteInput  in  1  EX/MEM regWrite
exMemMemReadInput  in  1  EX/MEM memRead
exMemWriteRegisterInput  in  5  EX/MEM destination
stallOutput  out  1  combinational; hold PC and IF/ID
ifFlushOutput  out  1  combinational; squash IF/ID next edge
pcRedirectOutput  out  1  combinational; take pcTargetOutput
pcTargetOutput  out  DATA_WIDTH  branch/jump target
validOutput, memToRegOutput, regWriteOutput, memWriteOutput, memReadOutput, aluSrcOutput  out  1 each  ID/EX registered
aluOpOutput  out  4  ID/EX registered
dataRsOutput, dataRtOutput, immediateExtendedOutput  out  DATA_WIDTH  ID/EX registered
addressRsOutput, addressRtOutput, writeRegisterOutput  out  5  ID/EX registered; writeRegister is already resolved by regDst
funcOutput  out  6  ID/EX registered

Behaviour:
Reset:
- All ID/EX outputs are 0 and all registers are 0, asynchronously.
- Combinational outputs are 0 while reset=0.

Decode, by opcode:
- R 0x00: regDst=rd, regWrite, aluOp=0010.
- lw 0x23: aluSrc, memRead, memToReg, regWrite, aluOp=0000.
- sw 0x2B: aluSrc, memWrite, aluOp=0000.
- addi 0x08: aluSrc, regWrite, aluOp=0000, sign-extended immediate.
- ori 0x0D: aluSrc, regWrite, aluOp=0011, zero-extended immediate.
- beq 0x04 / bne 0x05: aluOp=0001, no write.
- j 0x02: no write.
- Any other opcode: all controls 0, validOutput still 1.

Operand usage:
- rs is used by every instruction except j.
- rt is used by R, sw, beq and bne.

Register file:
- Writes on the rising edge when regWriteInput=1, index != 0 and index < NUM_REGS.
- Reads are combinational.
- Same-cycle write to the read index returns writeDataInput (bypass).
- Register 0 always reads 0.

Hazards (stall evaluated only when validInput=1):
- Load-use: ID/EX validOutput & memReadOutput & writeRegisterOutput != 0 & it matches a used source. Stall 1 cycle.
- Branch operand (beq/bne only): stall if either of the following matches rs or rt and is nonzero:
  - ID/EX validOutput & regWriteOutput & writeRegisterOutput;
  - exMemRegWriteInput & exMemWriteRegisterInput.
- A lw feeding a branch therefore stalls 2 cycles.

On stall:
- stallOutput=1.
- ID/EX loads a bubble: all controls 0, validOutput=0.
- No redirect is issued.

No stall, validInput=1:
- ID/EX captures the decode at the next edge, validOutput=1.

validInput=0:
- ID/EX loads a bubble.
- Stall, redirect and flush are all 0.

Branch/jump resolution (only when validInput=1 and no stall):
- beq taken when rs==rt; bne taken when rs!=rt.
- Branch target = pc4Input + (sext(imm16) << 2), modulo 2^DATA_WIDTH.
- Jump target = {pc4Input[DATA_WIDTH-1:28], instr[25:0], 2'b00}.
- When taken: pcRedirectOutput=1 and ifFlushOutput=1 for that cycle.
- The branch/jump itself still enters ID/EX as valid with regWrite=0.

Simultaneous events:
- Stall has priority over redirect.
- The WB write and the bypass read in the same cycle are both honoured.

Test Plan:
- Reset held low, then raised -> all outputs 0. Then lw $t0(8), 0($zero) -> next edge validOutput=1, memReadOutput=1, writeRegisterOutput=8, aluOpOutput=0000.
- WB writes $9=0x1234 on the same cycle ID decodes add $10,$9,$9 -> dataRsOutput=dataRtOutput=0x00001234 after the edge.
- lw $8 followed by add $11,$8,$8 -> stallOutput=1 for exactly 1 cycle; bubble with validOutput=0; add issues on the following edge.
- beq $8,$8,+4 at pc4=0x100 with no hazard -> pcRedirectOutput=1, ifFlushOutput=1, pcTargetOutput=0x110. bne with equal operands -> no redirect.
- lw $8 followed by beq $8,$0 -> stallOutput=1 for 2 cycles, then resolves.
- NUM_REGS=16: write $20=5, then read $20 -> 0. j 0x0000040 at pc4=0x10000004 -> target 0x10000100. reset asserted mid-stall -> all outputs 0 immediately.
